ysyx_22050598_exu_ctrl: RTL
===========================

// Module: ysyx_22050598_exu_ctrl
// PURPOSE
//   Execute-stage sequencer between decode (IDU) and writeback, around the combinational EXU.
//   Registers one decoded instruction and drives the EXU from those registers.
//   Single-cycle ops: captures the EXU result. Multi-cycle ops (M-ext mul/div): starts and waits on an iterative unit.
//   Presents the result to writeback over valid/ready, counts retired instructions, and halts the core on ebreak or timeout.
// PARAMETERS
//   XLEN        64   datapath width
//   MC_TIMEOUT  64   max MC_WAIT cycles before error halt (>=2)
//   CNT_W       64   width of retired-instruction counter
// PORTS
//   clk         in   1     core clock, all state on posedge
//   rst_n       in   1     asynchronous active-low reset
//   id_valid    in   1     decode holds an instruction
//   id_ready    out  1     controller accepts this cycle
//   id_rd       in   5     destination register
//   id_opcode   in   7     opcode
//   id_funct3   in   3     funct3
//   id_funct7   in   7     funct7
//   id_rdata1   in   XLEN  rs1 value
//   id_rdata2   in   XLEN  rs2 value
//   id_imm      in   XLEN  sign-extended immediate
//   ex_rd, ex_opcode, ex_funct3, ex_funct7, ex_rdata1, ex_rdata2, ex_imm  out  (as id_*)  registered EXU operands
//   ex_wen      in   1     EXU write enable
//   ex_waddr    in   5     EXU write address
//   ex_wdata    in   XLEN  EXU result
//   ex_ebreak   in   1     EXU decoded ebreak
//   mc_start    out  1     one-cycle start pulse to mul/div unit
//   mc_abort    out  1     one-cycle abort pulse to mul/div unit
//   mc_done     in   1     mul/div result valid
//   mc_result   in   XLEN  mul/div result
//   wb_valid    out  1     result available
//   wb_ready    in   1     writeback accepts
//   wb_wen      out  1     register write enable, forced 0 when wb_waddr==0
//   wb_waddr    out  5     write address
//   wb_wdata    out  XLEN  write data
//   flush       in   1     kill in-flight instruction
//   halt        out  1     sticky; core stopped
//   halt_err    out  1     sticky; halt caused by mul/div timeout
//   inst_cnt    out  CNT_W retired instructions
// BEHAVIOUR
//   - Reset: state=IDLE; all registered outputs 0 (ex_*, wb_*, halt, halt_err, inst_cnt, timeout counter).
//     id_ready=1 during reset (decoded from IDLE).
//   - States: IDLE, EXEC, MC_WAIT, WB, HALT (one-hot or binary, encoding free).
//   - id_ready = !flush && (IDLE || (WB && wb_ready)).
//     Capture on id_valid && id_ready; captured values load ex_*.
//   - Capture goes to MC_WAIT if is_muldiv(opcode, funct7), else to EXEC.
//     is_muldiv: opcode is OP (0110011) or OP_32 (0111011) and funct7==0000001.
//   - EXEC (exactly 1 cycle):
//     - ex_ebreak=1 -> HALT, halt=1, no wb_valid, not counted.
//     - Otherwise wb_* <= {ex_wen && ex_waddr!=0, ex_waddr, ex_wdata}, then WB.
//   - MC_WAIT:
//     - mc_start=1 in the first MC_WAIT cycle only. mc_done is honoured from that cycle on.
//     - On mc_done: wb_* <= {ex_rd!=0, ex_rd, mc_result}, then WB.
//     - Timeout counter clears on entry and increments each cycle without mc_done.
//       Value MC_TIMEOUT-1 with no mc_done -> HALT, halt=1, halt_err=1, mc_abort=1 that cycle.
//   - WB:
//     - wb_valid=1; wb_* stable until wb_valid && wb_ready.
//     - Handshake: inst_cnt++ (wraps at 2^CNT_W), then next state is
//       EXEC/MC_WAIT if a new instruction is captured the same cycle (back-to-back), else IDLE.
//   - Latency capture->wb_valid: 1 cycle single-cycle; done cycle + 1 for mul/div.
//   - flush (not in HALT): next state IDLE; wb_valid drops next cycle; no inst_cnt increment.
//     - Flush in MC_WAIT pulses mc_abort; mc_done arriving that cycle is discarded.
//     - Flush beats id_valid the same cycle (no capture).
//     - Flush beats wb_ready in WB (no retire).
//   - HALT is absorbing until rst_n; id_ready=0, wb_valid=0; flush ignored.
//   - Reset asserted mid-operation: immediate return to reset values; any in-flight mul/div is
//     abandoned (the unit shares rst_n).
// STRUCTURE
//   - Shared defines: opcode constants (OP, OP_32, ALU_IMM, CSR_BREAK), MULDIV_FUNCT7, state
//     encodings; no local magic numbers.
//   - One sub-module: ysyx_22050598_exu_timeout (loadable down-counter with expired flag).
//     FSM, operand registers and WB registers stay in this file.
// TESTING
//   1 addi x5,x0,3 (ex_wen=1, ex_wdata=3); wb_ready=1
//     -> wb_valid 1 cycle after EXEC, wb={1,5,3}, inst_cnt=1.
//   2 Two back-to-back addi with id_valid held and wb_ready=1
//     -> second captured on first's WB handshake, no IDLE bubble, inst_cnt=2.
//   3 mul x6 (funct7=0000001); mc_done 4 cycles after mc_start, mc_result=0x2A
//     -> exactly one mc_start pulse, wb={1,6,0x2A}, no EXU result used.
//   4 wb_ready low 5 cycles in WB
//     -> wb_* stable throughout, id_ready=0, single retire when wb_ready rises.
//   5 mul with mc_done never asserted, MC_TIMEOUT=8
//     -> mc_abort and halt=halt_err=1 on the 8th MC_WAIT cycle, id_ready stays 0.
//   6 ebreak captured -> halt=1, no wb_valid, inst_cnt unchanged.
//     flush in MC_WAIT together with mc_done -> IDLE, mc_abort=1, no retire.

Source files
------------

// File: rtl/ysyx_22050598_exu_ctrl_pkg.sv
// Shared constants, state encoding and decode helper
// for the execute-stage sequencer.
package ysyx_22050598_exu_ctrl_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] ALU_IMM   = 7'b0010011;
  localparam logic [6:0] CSR_BREAK = 7'b1110011;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_MC_WAIT = 3'd2,
    S_WB      = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  function automatic logic is_muldiv(
    input logic [6:0] opcode,
    input logic [6:0] funct7
  );
    return ((opcode == OP) || (opcode == OP_32))
      && (funct7 == MULDIV_FUNCT7);
  endfunction

endpackage

// File: rtl/ysyx_22050598_exu_ctrl_if.sv
// Bundle of IDU, EXU, mul/div, writeback and status signals.
// master: the controller; slave: the surrounding core.
interface ysyx_22050598_exu_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);

  logic            id_valid;
  logic            id_ready;
  logic [4:0]      id_rd;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [XLEN-1:0] id_rdata1;
  logic [XLEN-1:0] id_rdata2;
  logic [XLEN-1:0] id_imm;

  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [XLEN-1:0] ex_rdata1;
  logic [XLEN-1:0] ex_rdata2;
  logic [XLEN-1:0] ex_imm;

  logic            ex_wen;
  logic [4:0]      ex_waddr;
  logic [XLEN-1:0] ex_wdata;
  logic            ex_ebreak;

  logic            mc_start;
  logic            mc_abort;
  logic            mc_done;
  logic [XLEN-1:0] mc_result;

  logic            wb_valid;
  logic            wb_ready;
  logic            wb_wen;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;

  logic            flush;
  logic            halt;
  logic            halt_err;
  logic [CNT_W-1:0] inst_cnt;

  modport master (
    input  id_valid, id_rd, id_opcode,
    input  id_funct3, id_funct7,
    input  id_rdata1, id_rdata2, id_imm,
    output id_ready,
    output ex_rd, ex_opcode, ex_funct3,
    output ex_funct7, ex_rdata1,
    output ex_rdata2, ex_imm,
    input  ex_wen, ex_waddr, ex_wdata,
    input  ex_ebreak,
    output mc_start, mc_abort,
    input  mc_done, mc_result,
    output wb_valid, wb_wen,
    output wb_waddr, wb_wdata,
    input  wb_ready,
    input  flush,
    output halt, halt_err, inst_cnt
  );

  modport slave (
    output id_valid, id_rd, id_opcode,
    output id_funct3, id_funct7,
    output id_rdata1, id_rdata2, id_imm,
    input  id_ready,
    input  ex_rd, ex_opcode, ex_funct3,
    input  ex_funct7, ex_rdata1,
    input  ex_rdata2, ex_imm,
    output ex_wen, ex_waddr, ex_wdata,
    output ex_ebreak,
    input  mc_start, mc_abort,
    output mc_done, mc_result,
    input  wb_valid, wb_wen,
    input  wb_waddr, wb_wdata,
    output wb_ready,
    output flush,
    input  halt, halt_err, inst_cnt
  );

endinterface

// File: rtl/ysyx_22050598_exu_timeout.sv
// Loadable down-counter bounding the mul/div wait.
// Ports: clk, rst_n, load, dec in; expired out (count is zero).
module ysyx_22050598_exu_timeout #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int TW = $clog2(MC_TIMEOUT);

  logic [TW-1:0] cnt;

  // Loaded with MC_TIMEOUT-1 so zero marks the last allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(MC_TIMEOUT - 1);
    end else if (dec && !expired) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ysyx_22050598_exu_ctrl.sv
// Execute-stage sequencer: latches one decoded instruction, waits on EXU or mul/div,
// hands the result to writeback. Ports: clk, rst_n, io (bundle, master side).
module ysyx_22050598_exu_ctrl
  import ysyx_22050598_exu_ctrl_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050598_exu_ctrl_if.master io
);

  state_t state;
  state_t state_n;

  logic cap;
  logic muldiv;
  logic mc_first;
  logic expired;
  logic to_load;
  logic to_dec;
  logic ld_exec;
  logic ld_mc;
  logic retire;
  logic go_halt;
  logic go_err;

  logic            wen_d;
  logic [4:0]      waddr_d;
  logic [XLEN-1:0] wdata_d;

  assign muldiv = is_muldiv(io.id_opcode, io.id_funct7);

  assign io.id_ready = !io.flush
    && ((state == S_IDLE)
    || ((state == S_WB) && io.wb_ready));

  assign cap      = io.id_valid && io.id_ready;
  assign to_load  = cap && muldiv;
  assign io.wb_valid = (state == S_WB);
  assign io.mc_start = (state == S_MC_WAIT) && mc_first;

  ysyx_22050598_exu_timeout #(
    .MC_TIMEOUT(MC_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (to_load),
    .dec    (to_dec),
    .expired(expired)
  );

  always_comb begin
    state_n     = state;
    io.mc_abort = 1'b0;
    ld_exec     = 1'b0;
    ld_mc       = 1'b0;
    retire      = 1'b0;
    to_dec      = 1'b0;
    go_halt     = 1'b0;
    go_err      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cap) begin
          state_n = muldiv ? S_MC_WAIT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (io.flush) begin
          state_n = S_IDLE;
        end else if (io.ex_ebreak) begin
          state_n = S_HALT;
          go_halt = 1'b1;
        end else begin
          state_n = S_WB;
          ld_exec = 1'b1;
        end
      end
      S_MC_WAIT: begin
        // Flush wins over a same-cycle mc_done.
        if (io.flush) begin
          state_n     = S_IDLE;
          io.mc_abort = 1'b1;
        end else if (io.mc_done) begin
          state_n = S_WB;
          ld_mc   = 1'b1;
        end else if (expired) begin
          state_n     = S_HALT;
          io.mc_abort = 1'b1;
          go_halt     = 1'b1;
          go_err      = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      S_WB: begin
        if (io.flush) begin
          state_n = S_IDLE;
        end else if (io.wb_ready) begin
          retire = 1'b1;
          if (!cap) begin
            state_n = S_IDLE;
          end else begin
            state_n = muldiv ? S_MC_WAIT : S_EXEC;
          end
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    unique case (1'b1)
      ld_mc: begin
        wen_d   = (io.ex_rd != 5'd0);
        waddr_d = io.ex_rd;
        wdata_d = io.mc_result;
      end
      default: begin
        wen_d   = io.ex_wen
          && (io.ex_waddr != 5'd0);
        waddr_d = io.ex_waddr;
        wdata_d = io.ex_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mc_first <= 1'b0;
    end else begin
      state    <= state_n;
      mc_first <= to_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.ex_rd     <= '0;
      io.ex_opcode <= '0;
      io.ex_funct3 <= '0;
      io.ex_funct7 <= '0;
      io.ex_rdata1 <= '0;
      io.ex_rdata2 <= '0;
      io.ex_imm    <= '0;
    end else if (cap) begin
      io.ex_rd     <= io.id_rd;
      io.ex_opcode <= io.id_opcode;
      io.ex_funct3 <= io.id_funct3;
      io.ex_funct7 <= io.id_funct7;
      io.ex_rdata1 <= io.id_rdata1;
      io.ex_rdata2 <= io.id_rdata2;
      io.ex_imm    <= io.id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.wb_wen   <= 1'b0;
      io.wb_waddr <= '0;
      io.wb_wdata <= '0;
    end else if (ld_exec || ld_mc) begin
      io.wb_wen   <= wen_d;
      io.wb_waddr <= waddr_d;
      io.wb_wdata <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.halt     <= 1'b0;
      io.halt_err <= 1'b0;
      io.inst_cnt <= '0;
    end else begin
      if (go_halt) begin
        io.halt <= 1'b1;
      end
      if (go_err) begin
        io.halt_err <= 1'b1;
      end
      if (retire) begin
        io.inst_cnt <= io.inst_cnt + CNT_W'(1);
      end
    end
  end

endmodule
